// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the parametrised up/down counter.
// Mode selectors and the per-edge priority decision.
package updown_counter_pkg;

  localparam int unsigned CNT_MODE_WRAP = 0;
  localparam int unsigned CNT_MODE_SAT  = 1;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    HOLD = 2'd3
  } cnt_op_e;

endpackage

// File: rtl/updown_next_val.sv
// Next-step value for the up/down counter.
// Flags a boundary crossing (wrap or blocked saturating step).
module updown_next_val
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter int unsigned SAT_MODE = CNT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_hit
);

  localparam logic [WIDTH-1:0] MAX_C  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic             SAT    = (SAT_MODE == CNT_MODE_SAT);

  logic top_hit;
  logic bot_hit;

  // >= keeps the result in range even if count ever exceeds MAX_VAL
  assign top_hit = (count >= MAX_C);
  assign bot_hit = (count == ZERO_C);

  always_comb begin
    next_count   = count;
    boundary_hit = 1'b0;
    if (up_down) begin
      if (top_hit) begin
        boundary_hit = 1'b1;
        next_count   = SAT ? MAX_C : ZERO_C;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (bot_hit) begin
        boundary_hit = 1'b1;
        next_count   = SAT ? ZERO_C : MAX_C;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with clear, clamped load and boundary flags.
// Priority per edge: clear > load > enable > hold.
module param_updown_counter
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter int unsigned SAT_MODE = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             event_pulse
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be >= 2");
    end
    if (MAX_VAL == 0) begin : g_bad_max0
      $error("param_updown_counter: MAX_VAL must be > 0");
    end
    if (MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
      $error("param_updown_counter: MAX_VAL exceeds 2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

  cnt_op_e          op;
  logic [WIDTH-1:0] step_val;
  logic             step_hit;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] count_d;
  logic             pulse_d;

  updown_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .SAT_MODE(SAT_MODE)
  ) u_next (
    .count       (count),
    .up_down     (up_down),
    .next_count  (step_val),
    .boundary_hit(step_hit)
  );

  assign load_clamp = (load_val > MAX_C) ? MAX_C : load_val;

  always_comb begin
    op = HOLD;
    if (clear)       op = CLR;
    else if (load)   op = LOAD;
    else if (enable) op = STEP;
  end

  always_comb begin
    count_d = count;
    pulse_d = 1'b0;
    unique case (op)
      CLR:  count_d = '0;
      LOAD: count_d = load_clamp;
      STEP: begin
        count_d = step_val;
        pulse_d = step_hit;
      end
      HOLD: count_d = count;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      event_pulse <= 1'b0;
    end else begin
      count       <= count_d;
      event_pulse <= pulse_d;
    end
  end

  assign at_max = (count == MAX_C);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: wrap, saturate and full-range
// instances share one stimulus stream; expected values are hand-computed.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       load;
  logic [3:0] load_val4;
  logic [7:0] load_val8;
  logic       enable;
  logic       up_down;

  logic [3:0] w_count;
  logic       w_max, w_min, w_pulse;
  logic [3:0] s_count;
  logic       s_max, s_min, s_pulse;
  logic [7:0] f_count;
  logic       f_max, f_min, f_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val4), .enable(enable), .up_down(up_down),
    .count(w_count), .at_max(w_max), .at_min(w_min),
    .event_pulse(w_pulse)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val4), .enable(enable), .up_down(up_down),
    .count(s_count), .at_max(s_max), .at_min(s_min),
    .event_pulse(s_pulse)
  );

  param_updown_counter #(.WIDTH(8)) u_full (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val8), .enable(enable), .up_down(up_down),
    .count(f_count), .at_max(f_max), .at_min(f_min),
    .event_pulse(f_pulse)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld4(input logic [3:0] v);
    clear = 0; enable = 0; load = 1; load_val4 = v;
    tick();
    load = 0;
  endtask

  initial begin
    reset_n = 0; clear = 0; load = 0; enable = 0; up_down = 1;
    load_val4 = '0; load_val8 = '0;
    #12;
    chk("rst_cnt", int'(w_count), 0);
    chk("rst_min", int'(w_min), 1);
    chk("rst_max", int'(w_max), 0);
    chk("rst_pls", int'(w_pulse), 0);
    chk("rst_fcnt", int'(f_count), 0);

    // async reset mid-operation
    tick();
    reset_n = 1;
    ld4(4'd5);
    chk("ld5", int'(w_count), 5);
    #2 reset_n = 0;
    #1;
    chk("arst_cnt", int'(w_count), 0);
    chk("arst_min", int'(w_min), 1);
    chk("arst_pls", int'(w_pulse), 0);
    reset_n = 1; enable = 1; up_down = 1;
    tick();
    chk("post_rst", int'(w_count), 1);

    // wrap up
    ld4(4'd8);
    enable = 1; up_down = 1;
    tick();
    chk("wu9", int'(w_count), 9);
    chk("wu9_max", int'(w_max), 1);
    chk("wu9_pls", int'(w_pulse), 0);
    tick();
    chk("wu0", int'(w_count), 0);
    chk("wu0_pls", int'(w_pulse), 1);
    tick();
    chk("wu1", int'(w_count), 1);
    chk("wu1_pls", int'(w_pulse), 0);

    // wrap down
    ld4(4'd1);
    enable = 1; up_down = 0;
    tick();
    chk("wd0", int'(w_count), 0);
    chk("wd0_min", int'(w_min), 1);
    chk("wd0_pls", int'(w_pulse), 0);
    tick();
    chk("wd9", int'(w_count), 9);
    chk("wd9_pls", int'(w_pulse), 1);
    tick();
    chk("wd8", int'(w_count), 8);
    chk("wd8_pls", int'(w_pulse), 0);

    // saturate
    ld4(4'd9);
    enable = 1; up_down = 1;
    tick();
    chk("su9a", int'(s_count), 9);
    chk("su9a_pls", int'(s_pulse), 1);
    tick();
    chk("su9b", int'(s_count), 9);
    chk("su9b_pls", int'(s_pulse), 1);
    up_down = 0;
    tick();
    chk("sd8", int'(s_count), 8);
    chk("sd8_pls", int'(s_pulse), 0);
    ld4(4'd0);
    enable = 1; up_down = 0;
    tick();
    chk("sd0", int'(s_count), 0);
    chk("sd0_pls", int'(s_pulse), 1);

    // priority and clamp
    enable = 0; clear = 1; load = 1; load_val4 = 4'd3;
    tick();
    chk("clr_pri", int'(w_count), 0);
    clear = 0; load = 1; load_val4 = 4'd14; enable = 1; up_down = 1;
    tick();
    chk("clamp", int'(w_count), 9);
    chk("clamp_pls", int'(w_pulse), 0);
    load = 0; enable = 0;
    tick();
    chk("hold9", int'(w_count), 9);
    chk("hold9_pls", int'(w_pulse), 0);

    // full range on the 8-bit instance
    clear = 1;
    tick();
    clear = 0; enable = 1; up_down = 1;
    pulses = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (f_pulse) pulses++;
      if (i == 255) begin
        chk("f255", int'(f_count), 255);
        chk("f255_max", int'(f_max), 1);
      end
    end
    chk("f_wrap", int'(f_count), 0);
    chk("f_pulses", pulses, 1);
    repeat (5) tick();
    chk("f5", int'(f_count), 5);
    enable = 0;
    repeat (3) tick();
    chk("f_hold", int'(f_count), 5);
    chk("f_hold_pls", int'(f_pulse), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised up/down counter; next generation of the team's fixed 4-bit up/down counter.
- Adds configurable width and modulus, wrap or saturate mode, synchronous clear and parallel load, and boundary flags plus a wrap/saturate event pulse.
- Used as a general event/position counter in timing and control paths; drives flags directly into neighbouring FSMs.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL (must be <= 2**WIDTH-1).
- SAT_MODE, 0, 0 = wrap at boundaries, 1 = saturate at boundaries.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- enable  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- count  output  WIDTH  current count (registered).
- at_max  output  1  count == MAX_VAL (combinational decode of count).
- at_min  output  1  count == 0 (combinational decode of count).
- event_pulse  output  1  registered one-cycle pulse: a wrap (SAT_MODE=0) or a blocked step (SAT_MODE=1) occurred on the last edge.

Behaviour:
- Reset (reset_n low, asynchronous): count=0, event_pulse=0. Hence at_min=1, at_max=0 (at_max=1 only if MAX_VAL=0, which is disallowed).
- Reset mid-operation clears immediately with no clock edge. The first edge after deassertion is evaluated normally.
- Per rising edge, priority is clear > load > enable > hold.
- clear=1: count<=0, event_pulse<=0.
- load=1: count<=min(load_val, MAX_VAL), i.e. out-of-range values clamp to MAX_VAL. event_pulse<=0.
- enable=1, up_down=1:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: SAT_MODE=0 gives count<=0 and event_pulse<=1; SAT_MODE=1 holds MAX_VAL and sets event_pulse<=1.
- enable=1, up_down=0:
  - count>0: count-1.
  - count==0: SAT_MODE=0 gives count<=MAX_VAL and event_pulse<=1; SAT_MODE=1 holds 0 and sets event_pulse<=1.
- enable=0 and no clear/load: count holds, event_pulse<=0.
- event_pulse is high for exactly one cycle, coincident with the updated count value. Back-to-back boundary events keep it high on consecutive cycles.
- Latency: count and event_pulse update 1 cycle after the qualifying edge. at_max/at_min add no latency.
- Arithmetic is unsigned, WIDTH bits. The next-value logic must never produce a value above MAX_VAL, including when MAX_VAL < 2**WIDTH-1.
- Changing up_down while enabled takes effect on the next edge; there is no dead cycle.
- Parameter checks: elaboration-time error if MAX_VAL > 2**WIDTH-1, MAX_VAL == 0, or WIDTH < 2.

Decomposition:
- Package updown_counter_pkg holds:
  - mode constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1;
  - an enum typedef for the priority decision (CLR, LOAD, STEP, HOLD), used internally and by bench coverage.
- One combinational sub-module, updown_next_val, is natural. It takes count, up_down, and the MAX_VAL/SAT_MODE parameters, and returns next_count and boundary_hit. The top level keeps the registers and priority mux.

Test Plan (WIDTH=4, MAX_VAL=9 unless noted):
- Reset/async: count=5, drop reset_n between edges -> count=0 immediately, at_min=1, event_pulse=0. Release reset_n and enable up -> count=1 after first edge.
- Wrap up, SAT_MODE=0: count=8, up for 3 edges -> count 9, 0, 1. at_max=1 at 9. event_pulse=1 only in the cycle count=0.
- Wrap down, SAT_MODE=0: count=1, down for 3 edges -> count 0, 9, 8. event_pulse=1 only in the cycle count=9.
- Saturate, SAT_MODE=1: count=9, up for 2 edges -> count stays 9, event_pulse=1 on both cycles. Then down -> count 8, event_pulse=0.
- Priority/clamp: clear=1, load=1, load_val=3 -> count=0. Then load=1, load_val=14, enable=1 -> count=9 (clamped), event_pulse=0.
- Full range (WIDTH=8, default MAX_VAL=255, wrap): 256 up-steps from 0 -> back to 0, exactly one event_pulse. Hold enable=0 -> count stable.
